dbus_responder: RTL
===================

# dbus_responder

Data-bus responder for the single-cycle MIPS core: it sits on the far side of the core's data port (`memwrite`/`memaddr`/`memwritedata` in, `memreaddata` out). It serves loads and stores from a word-addressed data RAM plus a small MMIO window. The MMIO window holds a free-running cycle counter, an LED register and a buffered byte-console transmit queue with a valid/ready output. Reads are combinational so the single-cycle core completes a load in one cycle. All state updates on the rising clock edge.

## Interface
- `RAM_WORDS`, 64: data RAM depth in 32-bit words; power of two.
- `FIFO_DEPTH`, 8: console TX queue depth in bytes; power of two, ≥2.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `memwrite` in 1: store strobe from core; write takes effect at the next rising edge.
- `memaddr` in 32: byte address from core ALU; bits [1:0] ignored (word access only).
- `memwritedata` in 32: store data.
- `memreaddata` out 32: load data, combinational from `memaddr` and current state.
- `led` out 16: LED register.
- `tx_valid` out 1: console byte available.
- `tx_data` out 8: head byte of TX queue.
- `tx_ready` in 1: console accepts `tx_data` this cycle.

## Operation
- Decode: `memaddr[31:16] == 16'hFFFF` selects MMIO; otherwise RAM word index = `memaddr[log2(RAM_WORDS)+1:2]`. Upper RAM address bits are ignored, so RAM aliases.
- MMIO offsets (`memaddr[15:0]`):
  - 0x0000 CYCLE: read-only 32-bit counter; +1 every cycle, wraps 0xFFFFFFFF→0. Writes ignored.
  - 0x0004 LED: read/write; write loads `memwritedata[15:0]`; read returns {16'b0, led}.
  - 0x0008 TXDATA: write pushes `memwritedata[7:0]`; read returns 0.
  - 0x000C TXSTAT: read returns {overflow, 31-bit zero-extended count}; any write clears overflow.
  - Any other MMIO offset: read 0, write ignored.
- TX queue:
  - `tx_valid` = count≠0; `tx_data` = head byte.
  - Pop when `tx_valid & tx_ready`.
  - Push when full and no pop in the same cycle: byte dropped, overflow set (sticky).
  - Push and pop in the same cycle: both occur, count unchanged. This holds when full and when count=1; never counts as overflow.
  - A write to TXSTAT in the same cycle as a dropped push leaves overflow set (set wins).
  - Read/write pointers wrap modulo `FIFO_DEPTH`.
- Loads see pre-edge state: a TXSTAT read in a push cycle returns the old count; a RAM read of the word being written returns old data.
- Reset:
  - CYCLE=0, `led`=0, queue empty (`tx_valid`=0, pointers/count 0), overflow=0.
  - RAM contents are not reset.
  - `memwrite` during a reset cycle is ignored for MMIO but still writes RAM.
  - Reset mid-drain discards queued bytes.

## Timing
- Load latency 0 cycles (combinational `memreaddata`).
- Store visible at the edge ending the `memwrite` cycle.
- After reset deasserts, CYCLE reads 0 in the first cycle and 1 in the next.
- TX push in cycle N → `tx_valid` high in cycle N+1 (no fall-through).
- `tx_data`/`tx_valid` are registered-state outputs, stable through the cycle; no combinational path from `tx_ready` to `tx_valid`.
- No combinational path from `memaddr` to `tx_*` or `led`.

## Structure
- Package `dbus_pkg`:
  - MMIO base (16'hFFFF) and the four offset constants.
  - TXSTAT field positions.
- Sub-module `tx_fifo` (params WIDTH=8, DEPTH): push/pop/full/empty/count/head; overflow logic stays in `dbus_responder`.
- Top: address decode, RAM array, CYCLE counter, LED register, read mux.

## Test plan
- Reset, then idle 5 cycles: CYCLE reads 5 at cycle 5; `led`=0; `tx_valid`=0; TXSTAT=0.
- RAM: write 0xDEADBEEF to 0x00000010, read 0x00000010 → 0xDEADBEEF; read 0x00000110 (alias with RAM_WORDS=64) → 0xDEADBEEF; same-cycle read during write returns old value.
- LED: write 0x1234ABCD to 0xFFFF0004 → `led`=0xABCD, readback 0x0000ABCD; write to 0xFFFF0000 leaves CYCLE counting; read 0xFFFF0020 → 0.
- TX fill with `tx_ready`=0: push 'A'..'I' (9 bytes, DEPTH 8) → TXSTAT=0x80000008; then `tx_ready`=1 drains 'A'..'H' in order over 8 cycles, `tx_valid` falls; write TXSTAT → reads 0.
- Full + simultaneous push/pop with `tx_ready`=1: count stays 8, overflow stays 0, new byte emerges eighth.
- Reset asserted with 3 bytes queued and `led`=0x00FF: next cycle `tx_valid`=0, TXSTAT=0, `led`=0, CYCLE=0.

Source files
------------

// File: rtl/dbus_pkg.sv
// Shared constants for the data-bus responder: MMIO window base,
// register offsets and TXSTAT field layout.
package dbus_pkg;

  localparam logic [15:0] MMIO_BASE  = 16'hFFFF;

  localparam logic [15:0] OFF_CYCLE  = 16'h0000;
  localparam logic [15:0] OFF_LED    = 16'h0004;
  localparam logic [15:0] OFF_TXDATA = 16'h0008;
  localparam logic [15:0] OFF_TXSTAT = 16'h000C;

  localparam int TXSTAT_OVF_BIT = 31;
  localparam int TXSTAT_CNT_LSB = 0;

  function automatic logic is_mmio(input logic [31:0] addr);
    return addr[31:16] == MMIO_BASE;
  endfunction

endpackage

// File: rtl/dbus_responder_tx_fifo.sv
// Byte queue for console TX: push/pop with full/empty/count/head.
// Ports: clk, reset, push, pop, din in; head, full, empty, count out.
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full  = cnt == (PW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign count = cnt;
  assign head  = mem[rp];

  assign do_pop  = pop & ~empty;
  // A pop frees the slot this same edge, so a full queue still accepts.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/dbus_responder.sv
// Data-bus responder: word RAM plus MMIO (cycle counter, LED, TX queue).
// Ports: core data port in/out, led, tx_valid/tx_data/tx_ready console.
import dbus_pkg::*;

module dbus_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic [15:0] led,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   cycle;
  logic          ovf;
  logic          mmio;
  logic [15:0]   off;
  logic [AW-1:0] widx;
  logic          wr_mmio;
  logic          wr_led;
  logic          wr_tx;
  logic          wr_stat;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [31:0]   txstat;

  assign mmio = is_mmio(memaddr);
  assign off  = memaddr[15:0];
  assign widx = memaddr[AW+1:2];

  // MMIO stores are dropped while reset is held; RAM stores are not.
  assign wr_mmio = memwrite & mmio & ~reset;
  assign wr_led  = wr_mmio & (off == OFF_LED);
  assign wr_tx   = wr_mmio & (off == OFF_TXDATA);
  assign wr_stat = wr_mmio & (off == OFF_TXSTAT);

  assign tx_valid = ~empty;
  assign pop      = tx_valid & tx_ready;

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_tx),
    .pop   (pop),
    .din   (memwritedata[7:0]),
    .head  (tx_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (memwrite && !mmio) ram[widx] <= memwritedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle <= '0;
      led   <= '0;
      ovf   <= 1'b0;
    end else begin
      cycle <= cycle + 1'b1;
      if (wr_led) led <= memwritedata[15:0];
      // Dropped push outranks a clear in the same cycle.
      if (wr_tx && full && !pop) ovf <= 1'b1;
      else if (wr_stat)          ovf <= 1'b0;
    end
  end

  always_comb begin
    txstat = '0;
    txstat[TXSTAT_OVF_BIT] = ovf;
    txstat[TXSTAT_CNT_LSB +: CW] = count;
  end

  always_comb begin
    memreaddata = '0;
    if (mmio) begin
      unique case (off)
        OFF_CYCLE:  memreaddata = cycle;
        OFF_LED:    memreaddata = {16'b0, led};
        OFF_TXSTAT: memreaddata = txstat;
        default:    memreaddata = '0;
      endcase
    end else begin
      memreaddata = ram[widx];
    end
  end

endmodule
